// File: rtl/alu_cc.sv
// alu_cc: 16-bit execute-stage ALU with {n,z,p} condition-code generation
// and a registered condition-code flag set.
//
// Ports:
//   clock     in   1  rising-edge clock
//   reset_n   in   1  synchronous active-low reset (cc_q <= 3'b111)
//   op        in   3  0 ADD, 1 AND, 2 XOR, 3 LSHF, 4 RSHFL, 5 RSHFA, 6-7 reserved
//   a, b      in  16  operands; shifts use b[3:0] as the amount
//   result    out 16  combinational ALU result
//   cc        out  3  combinational {n,z,p} of result
//   value     in  16  word to classify (load / I/O data)
//   value_cc  out  3  combinational {n,z,p} of value
//   cc_load   in   1  update cc_q this cycle
//   cc_sel    in   1  cc_q source: 0 = cc, 1 = value_cc
//   cc_q      out  3  registered condition codes
module alu_cc (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic [2:0]  cc,
  input  logic [15:0] value,
  output logic [2:0]  value_cc,
  input  logic        cc_load,
  input  logic        cc_sel,
  output logic [2:0]  cc_q
);

  typedef enum logic [2:0] {
    OpAdd   = 3'd0,
    OpAnd   = 3'd1,
    OpXor   = 3'd2,
    OpLshf  = 3'd3,
    OpRshfl = 3'd4,
    OpRshfa = 3'd5
  } op_e;

  // Shared {n,z,p} classifier; exactly one bit is ever set.
  function automatic logic [2:0] classify(input logic [15:0] w);
    if (w[15]) begin
      return 3'b100;
    end else if (w == 16'h0000) begin
      return 3'b010;
    end else begin
      return 3'b001;
    end
  endfunction

  logic [3:0]         shamt;
  logic signed [15:0] a_signed;
  logic [2:0]         cc_d;

  assign shamt    = b[3:0];
  assign a_signed = a;

  always_comb begin
    result = 16'h0000;
    case (op)
      OpAdd:   result = a + b;
      OpAnd:   result = a & b;
      OpXor:   result = a ^ b;
      OpLshf:  result = a << shamt;
      OpRshfl: result = a >> shamt;
      OpRshfa: result = a_signed >>> shamt;
      default: result = 16'h0000;  // reserved ops read as zero
    endcase
  end

  assign cc       = classify(result);
  assign value_cc = classify(value);

  always_comb begin
    cc_d = cc_q;
    if (cc_load) begin
      cc_d = cc_sel ? value_cc : cc;
    end
  end

  // 3'b111 out of reset so the first conditional branch is taken.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cc_q <= 3'b111;
    end else begin
      cc_q <= cc_d;
    end
  end

endmodule

// File: tb/tb_alu_cc.sv
module tb_alu_cc;

  logic        clock;
  logic        reset_n;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic [2:0]  cc;
  logic [15:0] value;
  logic [2:0]  value_cc;
  logic        cc_load;
  logic        cc_sel;
  logic [2:0]  cc_q;

  int errors;
  int checks;

  alu_cc dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .cc       (cc),
    .value    (value),
    .value_cc (value_cc),
    .cc_load  (cc_load),
    .cc_sel   (cc_sel),
    .cc_q     (cc_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] x,
                                             input logic [15:0] y);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = (ux >= 32768) ? ux - 65536 : ux;
    longint p  = longint'(1) << (uy % 16);
    longint r;
    case (o)
      3'd0:    r = ux + uy;
      3'd1:    r = longint'(x & y);
      3'd2:    r = longint'(x ^ y);
      3'd3:    r = ux * p;
      3'd4:    r = ux / p;
      3'd5:    r = (sx >= 0) ? sx / p : -((-sx + p - 1) / p);
      default: r = 0;
    endcase
    r = r % 65536;
    if (r < 0) r = r + 65536;
    return r[15:0];
  endfunction

  function automatic logic [2:0] ref_cc(input logic [15:0] w);
    if (w >= 16'h8000) return 3'b100;
    if (w == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cc_load = 1'b0; cc_sel = 1'b0;
    op = 3'd0; a = 16'h0; b = 16'h0; value = 16'h0;
    step();
    checks++;
    if (cc_q !== 3'b111) begin
      errors++; $display("FAIL reset_cc_q: got %b want 111", cc_q);
    end
    step();
    checks++;
    if (cc_q !== 3'b111) begin
      errors++; $display("FAIL reset_hold: got %b want 111", cc_q);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_directed_alu();
    logic [2:0]  ops [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd5, 3'd4, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [15:0] as  [11] = '{16'h7FFF, 16'hFFFF, 16'hF0F0, 16'h1234, 16'h8000, 16'h8000,
                              16'h0001, 16'h0003, 16'hA5A5, 16'h8421, 16'h1234};
    logic [15:0] bs  [11] = '{16'h0001, 16'h0001, 16'h0FF0, 16'h1234, 16'h0004, 16'h0004,
                              16'h000F, 16'hFFF1, 16'h0000, 16'hFFF0, 16'h5678};
    logic [15:0] rs  [11] = '{16'h8000, 16'h0000, 16'h00F0, 16'h0000, 16'hF800, 16'h0800,
                              16'h8000, 16'h0006, 16'hA5A5, 16'h8421, 16'h0000};
    logic [2:0]  cs  [11] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001,
                              3'b100, 3'b001, 3'b100, 3'b100, 3'b010};
    for (int i = 0; i < 11; i++) begin
      op = ops[i]; a = as[i]; b = bs[i];
      #1;
      checks++;
      if (result !== rs[i]) begin
        errors++; $display("FAIL alu_result[%0d]: got %h want %h", i, result, rs[i]);
      end
      checks++;
      if (cc !== cs[i]) begin
        errors++; $display("FAIL alu_cc[%0d]: got %b want %b", i, cc, cs[i]);
      end
    end
  endtask

  task automatic test_classifier();
    logic [15:0] vs [5] = '{16'h0000, 16'h8001, 16'h7FFF, 16'hFFFF, 16'h0001};
    logic [2:0]  cs [5] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    for (int i = 0; i < 5; i++) begin
      value = vs[i];
      #1;
      checks++;
      if (value_cc !== cs[i]) begin
        errors++; $display("FAIL value_cc[%0d]: got %b want %b", i, value_cc, cs[i]);
      end
    end
  endtask

  task automatic test_random_alu();
    logic [15:0] want;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
      value = 16'($urandom);
      if (i % 10 == 0) a = 16'h0;
      #1;
      want = ref_result(op, a, b);
      checks++;
      if (result !== want) begin
        errors++;
        $display("FAIL rand_result op=%0d a=%h b=%h: got %h want %h", op, a, b, result, want);
      end
      checks++;
      if (cc !== ref_cc(want)) begin
        errors++; $display("FAIL rand_cc: got %b want %b", cc, ref_cc(want));
      end
      checks++;
      if (value_cc !== ref_cc(value)) begin
        errors++; $display("FAIL rand_value_cc: got %b want %b", value_cc, ref_cc(value));
      end
    end
  endtask

  task automatic test_flags();
    reset_n = 1'b0; cc_load = 1'b0;
    step();
    reset_n = 1'b1;
    op = 3'd0; a = 16'hFFFF; b = 16'h0001; cc_load = 1'b1; cc_sel = 1'b0;
    step();
    checks++;
    if (cc_q !== 3'b010) begin
      errors++; $display("FAIL flag_load_cc: got %b want 010", cc_q);
    end
    cc_sel = 1'b1; value = 16'h9000;
    step();
    checks++;
    if (cc_q !== 3'b100) begin
      errors++; $display("FAIL flag_load_value: got %b want 100", cc_q);
    end
    cc_load = 1'b0; value = 16'h0000; cc_sel = 1'b0; a = 16'h0001; b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cc_q !== 3'b100) begin
        errors++; $display("FAIL flag_hold[%0d]: got %b want 100", i, cc_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] want;
    cc_load = 1'b1; cc_sel = 1'b0; op = 3'd0;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 16'h0000 : 16'h4000;
      b = 16'h0000;
      want = (i % 2 == 0) ? 3'b010 : 3'b001;
      step();
      checks++;
      if (cc_q !== want) begin
        errors++; $display("FAIL back_to_back[%0d]: got %b want %b", i, cc_q, want);
      end
    end
    cc_load = 1'b0;
  endtask

  task automatic test_reset_priority();
    reset_n = 1'b0; cc_load = 1'b1; cc_sel = 1'b1; value = 16'h0000;
    step();
    checks++;
    if (cc_q !== 3'b111) begin
      errors++; $display("FAIL reset_priority: got %b want 111", cc_q);
    end
    step();
    checks++;
    if (cc_q !== 3'b111) begin
      errors++; $display("FAIL reset_priority_hold: got %b want 111", cc_q);
    end
    // Load pending across reset release takes effect on the first released edge.
    reset_n = 1'b1;
    step();
    checks++;
    if (cc_q !== 3'b010) begin
      errors++; $display("FAIL release_load: got %b want 010", cc_q);
    end
    cc_load = 1'b0;
  endtask

  task automatic test_random_flags();
    logic [2:0] model;
    model = cc_q === 3'b010 ? 3'b010 : 3'b111;
    reset_n = 1'b0;
    step();
    model = 3'b111;
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 15) != 0);
      cc_load = 1'($urandom);
      cc_sel  = 1'($urandom);
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
      value = (i % 7 == 0) ? 16'h0 : 16'($urandom);
      #1;
      if (!reset_n) model = 3'b111;
      else if (cc_load) model = cc_sel ? ref_cc(value) : ref_cc(ref_result(op, a, b));
      step();
      checks++;
      if (cc_q !== model) begin
        errors++; $display("FAIL rand_cc_q[%0d]: got %b want %b", i, cc_q, model);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0; cc_load = 1'b0; cc_sel = 1'b0;
    op = 3'd0; a = 16'h0; b = 16'h0; value = 16'h0;
    #2;
    test_reset();
    test_directed_alu();
    test_classifier();
    test_random_alu();
    test_flags();
    test_back_to_back();
    test_reset_priority();
    test_random_flags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
